// File: rtl/mult_pkg.sv
// Shared types and constants for the sum-and-shift multiplier datapath.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic SHIFT1 = 1'b0;
  localparam logic SHIFT2 = 1'b1;

endpackage

// File: rtl/wide_shr.sv
// Combinational right shifter by 1 or 2 with zero or sign fill.
module wide_shr
  import mult_pkg::*;
#(
  parameter int N = 17
) (
  input  logic [N-1:0] src,
  input  logic         amt,
  input  logic         arith,
  output logic [N-1:0] dout
);

  logic fill;

  always_comb begin
    fill = arith & src[N-1];
    if (amt == SHIFT2) dout = {{2{fill}}, src[N-1:2]};
    else               dout = {fill, src[N-1:1]};
  end

endmodule

// File: rtl/prod_shift_reg.sv
// {HI, LO} product register with add-then-shift, iteration counter and
// IDLE/RUN/DONE sequencing for the sum-and-shift multiplier.
module prod_shift_reg
  import mult_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] lo_in,
  input  logic             shift_en,
  input  logic             load_hi,
  input  logic [WIDTH:0]   hi_in,
  input  logic             shift_amt,
  input  logic             arith,
  output logic [WIDTH:0]   hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic [1:0]       lsb_out,
  output logic [CW-1:0]    step_count,
  output logic             busy,
  output logic             done
);

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_HALF  = CW'(WIDTH / 2);

  state_t            state_q, state_d;
  logic [WIDTH:0]    hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              amt_q, amt_d;
  logic [2*WIDTH:0]  shr_src, shr_out;

  assign shr_src = {(load_hi ? hi_in : hi_q), lo_q};

  wide_shr #(.N(2 * WIDTH + 1)) u_shr (
    .src   (shr_src),
    .amt   (amt_q),
    .arith (arith),
    .dout  (shr_out)
  );

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      amt_q   <= SHIFT1;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      amt_q   <= amt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    amt_d   = amt_q;
    if (clear) begin
      state_d = IDLE;
      hi_d    = '0;
      lo_d    = '0;
      cnt_d   = '0;
    end else if (start) begin
      state_d = RUN;
      hi_d    = '0;
      lo_d    = lo_in;
      amt_d   = shift_amt;
      cnt_d   = (shift_amt == SHIFT2) ? CNT_HALF : CNT_FULL;
    end else if (shift_en && state_q == RUN) begin
      {hi_d, lo_d} = shr_out;
      cnt_d        = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) state_d = DONE;
    end
  end

  assign hi_out     = hi_q;
  assign lo_out     = lo_q;
  assign lsb_out    = lo_q[1:0];
  assign step_count = cnt_q;
  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_prod_shift_reg.sv
// Randomized and directed checks of prod_shift_reg against a behavioural product model.
module tb_prod_shift_reg;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          CLOCK = 1'b0;
  logic          RESET;
  logic          clear, start, shift_en, load_hi, shift_amt, arith;
  logic [W-1:0]  lo_in;
  logic [W:0]    hi_in;
  logic [W:0]    hi_out;
  logic [W-1:0]  lo_out;
  logic [1:0]    lsb_out;
  logic [CW-1:0] step_count;
  logic          busy, done;

  int total = 0;
  int bad   = 0;

  // model: product as one 2W+1 bit number, phase 0=idle 1=run 2=done
  logic [2*W:0] m_prod;
  int           m_cnt;
  int           m_phase;
  int           m_shift;

  prod_shift_reg #(.WIDTH(W)) dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .clear      (clear),
    .start      (start),
    .lo_in      (lo_in),
    .shift_en   (shift_en),
    .load_hi    (load_hi),
    .hi_in      (hi_in),
    .shift_amt  (shift_amt),
    .arith      (arith),
    .hi_out     (hi_out),
    .lo_out     (lo_out),
    .lsb_out    (lsb_out),
    .step_count (step_count),
    .busy       (busy),
    .done       (done)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prod  = '0;
    m_cnt   = 0;
    m_phase = 0;
    m_shift = 1;
  endtask

  task automatic model_step();
    logic [2*W:0] src;
    if (clear) begin
      m_prod  = '0;
      m_cnt   = 0;
      m_phase = 0;
    end else if (start) begin
      m_prod  = {{(W+1){1'b0}}, lo_in};
      m_shift = shift_amt ? 2 : 1;
      m_cnt   = W / m_shift;
      m_phase = 1;
    end else if (shift_en && m_phase == 1) begin
      src = load_hi ? {hi_in, m_prod[W-1:0]} : m_prod;
      if (arith) m_prod = $signed(src) >>> m_shift;
      else       m_prod = src >> m_shift;
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) m_phase = 2;
    end
  endtask

  task automatic compare();
    chk("hi_out",     hi_out,     m_prod[2*W:W]);
    chk("lo_out",     lo_out,     m_prod[W-1:0]);
    chk("lsb_out",    lsb_out,    m_prod[1:0]);
    chk("step_count", step_count, m_cnt);
    chk("busy",       busy,       m_phase == 1);
    chk("done",       done,       m_phase == 2);
  endtask

  // one clock: model follows the edge, outputs compared on the falling edge
  task automatic tick();
    @(posedge CLOCK);
    model_step();
    @(negedge CLOCK);
    compare();
  endtask

  task automatic idle_in();
    clear = 0; start = 0; shift_en = 0; load_hi = 0;
    shift_amt = 0; arith = 0; lo_in = '0; hi_in = '0;
  endtask

  task automatic do_start(input logic [W-1:0] lo, input logic amt);
    idle_in();
    start = 1; lo_in = lo; shift_amt = amt;
    tick();
    start = 0;
  endtask

  initial begin
    idle_in();
    RESET = 0;
    model_reset();
    @(negedge CLOCK);
    compare();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    RESET = 1;
    tick();

    // radix-2 logical
    do_start(8'hA5, 1'b0);
    chk("r2_start_cnt", step_count, 8);
    shift_en = 1; load_hi = 0; arith = 0;
    tick();
    chk("r2_lo1",  lo_out, 8'h52);
    chk("r2_lsb1", lsb_out, 2'b10);
    chk("r2_cnt1", step_count, 7);
    for (int i = 0; i < 7; i++) tick();
    chk("r2_lo8",   lo_out, 0);
    chk("r2_hi8",   hi_out, 0);
    chk("r2_done8", done, 1);

    // radix-4 arithmetic with adder load
    do_start(8'h0F, 1'b1);
    shift_en = 1; load_hi = 1; hi_in = 9'h1F0; arith = 1;
    tick();
    chk("r4_hi", hi_out, 9'h1FC);
    chk("r4_lo", lo_out, 8'h03);
    chk("r4_cnt", step_count, 3);

    // stall then resume
    shift_en = 0;
    for (int i = 0; i < 5; i++) begin
      hi_in = 9'($urandom);
      tick();
    end
    chk("stall_hi",   hi_out, 9'h1FC);
    chk("stall_lo",   lo_out, 8'h03);
    chk("stall_cnt",  step_count, 3);
    chk("stall_busy", busy, 1);
    shift_en = 1;
    for (int i = 0; i < 2; i++) begin
      hi_in = 9'($urandom);
      tick();
    end
    chk("resume_busy", busy, 1);
    tick();
    chk("resume_done", done, 1);

    // restart in RUN, then clear beating start
    do_start(8'($urandom), 1'b0);
    shift_en = 1;
    for (int i = 0; i < 5; i++) tick();
    chk("pre_restart_cnt", step_count, 3);
    do_start(8'h3C, 1'b0);
    chk("restart_lo",  lo_out, 8'h3C);
    chk("restart_hi",  hi_out, 0);
    chk("restart_cnt", step_count, 8);
    clear = 1; start = 1; lo_in = 8'hFF;
    tick();
    clear = 0; start = 0;
    chk("clear_lo",   lo_out, 0);
    chk("clear_cnt",  step_count, 0);
    chk("clear_busy", busy, 0);

    // DONE holds against shift requests
    do_start(8'h96, 1'b1);
    shift_en = 1; load_hi = 1; hi_in = 9'h0AB; arith = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("done_reached", done, 1);
    for (int i = 0; i < 3; i++) begin
      hi_in = 9'($urandom);
      arith = 1'($urandom);
      tick();
    end
    chk("done_hold", done, 1);
    do_start(8'h11, 1'b0);
    chk("done_cleared", done, 0);
    chk("busy_after_start", busy, 1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      clear     = ($urandom_range(0, 59) == 0);
      start     = ($urandom_range(0, 14) == 0);
      shift_en  = ($urandom_range(0, 3) != 0);
      load_hi   = 1'($urandom);
      hi_in     = 9'($urandom);
      lo_in     = 8'($urandom);
      shift_amt = 1'($urandom);
      arith     = 1'($urandom);
      tick();
    end

    // asynchronous reset mid-run
    do_start(8'hC3, 1'b0);
    shift_en = 1;
    tick();
    tick();
    #2 RESET = 0;
    #1 model_reset();
    compare();
    chk("async_busy", busy, 0);
    chk("async_cnt",  step_count, 0);
    @(negedge CLOCK);
    compare();
    RESET = 1;
    tick();
    chk("post_reset_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prod_shift_reg.md
Name: prod_shift_reg

Overview:
- Parametrised product register for the sum-and-shift multiplier datapath.
- Holds a combined {HI, LO} product register: HI is WIDTH+1 bits (adder result plus carry/sign), LO is WIDTH bits (the multiplier operand).
- Supports an add-then-shift in a single cycle, by 1 (radix-2) or 2 (radix-4), with logical or arithmetic fill.
- Counts iterations internally and flags completion, so the controller no longer counts steps itself.

Parameters:
- WIDTH, 8: operand width. Must be even and ≥ 4.
- CW, $clog2(WIDTH+1): width of the step counter (derived; never overridden).

Ports:
- CLOCK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear; highest priority after RESET.
- start  in  1  load lo_in into LO, zero HI, arm the counter, enter RUN.
- lo_in  in  WIDTH  multiplier operand captured on start.
- shift_en  in  1  perform one iteration this cycle (RUN only).
- load_hi  in  1  with shift_en: the shift source is {hi_in, LO} instead of {HI, LO}.
- hi_in  in  WIDTH+1  adder result from the datapath.
- shift_amt  in  1  0 = shift by 1, 1 = shift by 2; sampled on start and frozen for the run.
- arith  in  1  1 = fill with the MSB of the shift source, 0 = fill with zeros.
- hi_out  out  WIDTH+1  HI register.
- lo_out  out  WIDTH  LO register.
- lsb_out  out  2  LO[1:0]; recoding bits for the controller.
- step_count  out  CW  remaining iterations.
- busy  out  1  high while in RUN.
- done  out  1  high while in DONE.

Behaviour:
- Reset (RESET=0, asynchronous): HI=0, LO=0, step_count=0, state=IDLE, busy=0, done=0, frozen shift_amt=0.
- States: IDLE, RUN, DONE. busy = (state==RUN); done = (state==DONE). Both are registered-state decodes with no combinational input paths.
- Priority each cycle: clear > start > shift_en > hold.
- clear: HI=0, LO=0, step_count=0, go to IDLE. Allowed in any state.
- start (any state, including RUN, which restarts the run):
  - LO=lo_in, HI=0.
  - step_count = WIDTH when shift_amt=0, WIDTH/2 when shift_amt=1.
  - Go to RUN. busy rises in the next cycle.
- Iteration (RUN, shift_en=1):
  - src = load_hi ? {hi_in, LO} : {HI, LO}, 2*WIDTH+1 bits.
  - {HI, LO} <= src shifted right by 1 or 2 (frozen amount). Vacated MSBs take src[2*WIDTH] if arith=1, else 0.
  - step_count decrements by 1.
  - On the iteration where step_count goes 1→0, the next state is DONE.
- RUN with shift_en=0: all registers hold (stall), step_count holds.
- shift_en or load_hi in IDLE or DONE: ignored, registers hold.
- DONE: holds the product until start or clear. No timeout.
- Latency: a radix-2 run is WIDTH shift cycles from the first RUN cycle; radix-4 is WIDTH/2. done is first high the cycle after the last shift.
- hi_in is only consumed when shift_en=1 and load_hi=1. A plain load of HI without a shift is not supported.
- RESET deasserted mid-run: the block restarts in IDLE. A run is never resumed.

Decomposition:
- Package mult_pkg:
  - enum state_t {IDLE, RUN, DONE};
  - localparam SHIFT1=1'b0, SHIFT2=1'b1.
- One natural sub-module: wide_shr, a combinational right shifter of 2*WIDTH+1 bits by 1 or 2 with fill select.
- The top module holds the registers, FSM and counter.

Test Plan (WIDTH=8):
- Reset: assert RESET mid-operation → hi_out=0, lo_out=0, step_count=0, busy=0, done=0 immediately, without a clock edge.
- Radix-2 logical:
  - Stimulus: start, lo_in=8'hA5, shift_amt=0, arith=0; then shift_en=1, load_hi=0.
  - After the 1st shift: lo_out=8'h52, lsb_out=2'b10, step_count=7.
  - After the 8th shift: lo_out=0, hi_out=0, done=1.
- Radix-4 arithmetic with load:
  - Stimulus: start with lo_in=8'h0F, shift_amt=1; then shift_en=1, load_hi=1, hi_in=9'h1F0, arith=1.
  - Response: hi_out=9'h1FC, lo_out=8'h03, step_count=3.
- Stall:
  - Stimulus: during RUN, hold shift_en=0 for 5 cycles.
  - Response: hi_out, lo_out and step_count unchanged; busy stays 1.
  - Resuming with shift_en=1 completes after exactly the remaining steps.
- Restart and clear:
  - start in RUN with step_count=3: LO reloads, step_count=8.
  - clear together with start: IDLE, all outputs 0.
- DONE hold:
  - Stimulus: in DONE, apply shift_en=1 with load_hi=1 for 3 cycles.
  - Response: product unchanged, done stays 1.
  - A new start clears done in the next cycle.
